// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation-control responder: register offsets,
// FSM state encoding and the watchdog failure code.
package sim_ctrl_pkg;

   localparam logic [3:0]  OFF_TOHOST = 4'h0;
   localparam logic [3:0]  OFF_PUTC   = 4'h4;
   localparam logic [3:0]  OFF_CYCLE  = 4'h8;
   localparam logic [3:0]  OFF_STATUS = 4'hC;

   localparam logic [31:0] TMO_CODE   = 32'h0000_DEAD;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TMO
   } state_t;

endpackage

// File: rtl/sim_ctrl_watchdog.sv
// Saturating run-cycle counter with watchdog expiry compare.
module sim_ctrl_watchdog #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic [31:0] count,
   output logic        expire
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (run && (count != '1))
         count <= count + 32'd1;
   end

   assign expire = run && (count == 32'(TIMEOUT - 1));

endmodule

// File: rtl/sim_ctrl.sv
// Memory-mapped simulation-control responder (TOHOST verdict, PUTC console,
// CYCLE counter, STATUS). Optional SIM_CTRL_DISPLAY_EN adds console/verdict
// printing and ends the simulation one cycle after done rises.
module sim_ctrl
   import sim_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_we,
   input  logic        mem_re,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        hit,
   output logic        done,
   output logic        pass,
   output logic [31:0] fail_code,
   output logic [31:0] cycle_count,
   output logic        char_valid,
   output logic [7:0]  char_data
);

   state_t      state, state_nxt;
   logic [31:0] fail_nxt;
   logic [3:0]  off;
   logic        run, wr, expire;
   logic        unused_addr_lo;

   assign hit            = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign off            = {mem_addr[3:2], 2'b00};
   assign unused_addr_lo = ^mem_addr[1:0];
   assign run            = (state == ST_RUN);
   assign wr             = mem_we && hit && run;
   assign done           = (state != ST_RUN);
   assign pass           = (state == ST_PASS);

   sim_ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .count  (cycle_count),
      .expire (expire)
   );

   // A TOHOST write takes priority over a coincident watchdog expiry.
   always_comb begin
      state_nxt = state;
      fail_nxt  = fail_code;
      if (run) begin
         if (wr && (off == OFF_TOHOST) && (mem_wdata != '0)) begin
            if (mem_wdata == 32'd1) begin
               state_nxt = ST_PASS;
            end else begin
               state_nxt = ST_FAIL;
               fail_nxt  = mem_wdata >> 1;
            end
         end else if (expire) begin
            state_nxt = ST_TMO;
            fail_nxt  = TMO_CODE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_RUN;
         fail_code  <= '0;
         char_valid <= 1'b0;
         char_data  <= '0;
      end else begin
         state      <= state_nxt;
         fail_code  <= fail_nxt;
         char_valid <= wr && (off == OFF_PUTC);
         if (wr && (off == OFF_PUTC))
            char_data <= mem_wdata[7:0];
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (hit && mem_re) begin
         case (off)
            OFF_CYCLE:  mem_rdata = cycle_count;
            OFF_STATUS: mem_rdata = {29'b0, (state == ST_TMO), pass, done};
            default:    mem_rdata = '0;
         endcase
      end
   end

`ifdef SIM_CTRL_DISPLAY_EN
   logic done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done;
         if (char_valid)
            $write("%c", char_data);
         if (done && !done_q) begin
            $display("sim_ctrl: %s fail_code=%h cycles=%0d",
                     pass ? "PASS" : ((state == ST_TMO) ? "TIMEOUT" : "FAILED"),
                     fail_code, cycle_count);
            $finish;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sim_ctrl.sv
// Self-checking bench for sim_ctrl: decode table, directed corner sequences and
// randomized bus traffic against a behavioural model.
module tb_sim_ctrl;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam int unsigned TO   = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_we = 1'b0, mem_re = 1'b0;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic [31:0] mem_rdata, fail_code, cycle_count;
   logic        hit, done, pass, char_valid;
   logic [7:0]  char_data;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model
   bit              m_done, m_pass, m_tmo, m_cv;
   logic [31:0]     m_code;
   longint unsigned m_cnt;
   logic [7:0]      m_cd;

   sim_ctrl #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .hit         (hit),
      .done        (done),
      .pass        (pass),
      .fail_code   (fail_code),
      .cycle_count (cycle_count),
      .char_valid  (char_valid),
      .char_data   (char_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, got time %0t required < 1000000", $time);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return a[31:4] == BASE[31:4];
   endfunction

   function automatic logic [31:0] model_rdata();
      logic [31:0] a;
      a = mem_addr;
      if (!in_window(a) || !mem_re) return '0;
      if (a[3:2] == 2'd2) return m_cnt[31:0];
      if (a[3:2] == 2'd3) return {29'b0, m_tmo, m_pass, m_done};
      return '0;
   endfunction

   task automatic model_reset();
      m_done = 0; m_pass = 0; m_tmo = 0; m_cv = 0;
      m_code = '0; m_cnt = 0; m_cd = '0;
   endtask

   // One clock edge of the reference behaviour, using the inputs held during the cycle.
   task automatic model_edge();
      bit wr_win;
      wr_win = mem_we && in_window(mem_addr);
      if (m_done) begin
         m_cv = 0;
      end else begin
         if (wr_win && mem_addr[3:2] == 2'd0 && mem_wdata != 0) begin
            m_done = 1;
            if (mem_wdata == 1) m_pass = 1;
            else m_code = mem_wdata >> 1;
         end else if (m_cnt == TO - 1) begin
            m_done = 1;
            m_tmo  = 1;
            m_code = 32'h0000_DEAD;
         end
         m_cv = wr_win && mem_addr[3:2] == 2'd1;
         if (m_cv) m_cd = mem_wdata[7:0];
         if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
   endtask

   task automatic compare_all();
      check("hit", 32'(hit), 32'(in_window(mem_addr)));
      check("mem_rdata", mem_rdata, model_rdata());
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_pass));
      check("fail_code", fail_code, m_code);
      check("cycle_count", cycle_count, m_cnt[31:0]);
      check("char_valid", 32'(char_valid), 32'(m_cv));
      if (m_cv) check("char_data", 32'(char_data), 32'(m_cd));
   endtask

   task automatic step(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata);
      mem_we = we; mem_re = re; mem_addr = addr; mem_wdata = wdata;
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_we = 0; mem_re = 0; mem_addr = '0; mem_wdata = '0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic read_now(input logic [31:0] addr);
      mem_we = 0; mem_re = 1; mem_addr = addr; mem_wdata = '0;
      #1;
   endtask

   typedef struct {
      logic        we, re;
      logic [31:0] addr, wdata;
      logic        hit;
      logic [31:0] rdata;
      logic        done, pass;
      logic [31:0] code, cnt;
      logic        cv;
      logic [7:0]  cd;
   } vec_t;

   vec_t tbl[18];

   initial begin
      // {we, re, addr, wdata, hit, rdata, done, pass, fail_code, cycle_count, char_valid, char_data}
      tbl[0]  = '{0, 1, BASE + 32'h8, 32'h0,  1, 32'd0,  0, 0, 32'd0, 32'd0,  0, 8'h00};
      tbl[1]  = '{0, 1, BASE + 32'hB, 32'h0,  1, 32'd1,  0, 0, 32'd0, 32'd1,  0, 8'h00};
      tbl[2]  = '{0, 1, BASE + 32'hC, 32'h0,  1, 32'd0,  0, 0, 32'd0, 32'd2,  0, 8'h00};
      tbl[3]  = '{0, 1, BASE,         32'h0,  1, 32'd0,  0, 0, 32'd0, 32'd3,  0, 8'h00};
      tbl[4]  = '{0, 1, 32'h100,      32'h0,  0, 32'd0,  0, 0, 32'd0, 32'd4,  0, 8'h00};
      tbl[5]  = '{0, 0, BASE + 32'h8, 32'h0,  1, 32'd0,  0, 0, 32'd0, 32'd5,  0, 8'h00};
      tbl[6]  = '{1, 1, BASE + 32'h8, 32'h55, 1, 32'd6,  0, 0, 32'd0, 32'd6,  0, 8'h00};
      tbl[7]  = '{1, 0, BASE,         32'h0,  1, 32'd0,  0, 0, 32'd0, 32'd7,  0, 8'h00};
      tbl[8]  = '{1, 1, BASE + 32'h4, 32'h48, 1, 32'd0,  0, 0, 32'd0, 32'd8,  0, 8'h00};
      tbl[9]  = '{1, 0, BASE + 32'h4, 32'h69, 1, 32'd0,  0, 0, 32'd0, 32'd9,  1, 8'h48};
      tbl[10] = '{0, 0, 32'h100,      32'h0,  0, 32'd0,  0, 0, 32'd0, 32'd10, 1, 8'h69};
      tbl[11] = '{0, 1, BASE + 32'h8, 32'h0,  1, 32'd11, 0, 0, 32'd0, 32'd11, 0, 8'h00};
      tbl[12] = '{1, 0, BASE,         32'hB,  1, 32'd0,  0, 0, 32'd0, 32'd12, 0, 8'h00};
      tbl[13] = '{1, 0, BASE,         32'h1,  1, 32'd0,  1, 0, 32'd5, 32'd13, 0, 8'h00};
      tbl[14] = '{1, 1, BASE + 32'h4, 32'h21, 1, 32'd0,  1, 0, 32'd5, 32'd13, 0, 8'h00};
      tbl[15] = '{0, 1, BASE + 32'hC, 32'h0,  1, 32'd1,  1, 0, 32'd5, 32'd13, 0, 8'h00};
      tbl[16] = '{0, 1, 32'hFFFE_0008, 32'h0, 0, 32'd0,  1, 0, 32'd5, 32'd13, 0, 8'h00};
      tbl[17] = '{0, 1, BASE + 32'h8, 32'h0,  1, 32'd13, 1, 0, 32'd5, 32'd13, 0, 8'h00};

      // Decode/strobe table straight after reset
      do_reset();
      for (int i = 0; i < 18; i++) begin
         mem_we = tbl[i].we; mem_re = tbl[i].re; mem_addr = tbl[i].addr; mem_wdata = tbl[i].wdata;
         @(negedge clk);
         check($sformatf("tbl%0d_hit", i), 32'(hit), 32'(tbl[i].hit));
         check($sformatf("tbl%0d_rdata", i), mem_rdata, tbl[i].rdata);
         check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
         check($sformatf("tbl%0d_pass", i), 32'(pass), 32'(tbl[i].pass));
         check($sformatf("tbl%0d_code", i), fail_code, tbl[i].code);
         check($sformatf("tbl%0d_cnt", i), cycle_count, tbl[i].cnt);
         check($sformatf("tbl%0d_cv", i), 32'(char_valid), 32'(tbl[i].cv));
         if (tbl[i].cv) check($sformatf("tbl%0d_cd", i), 32'(char_data), 32'(tbl[i].cd));
         @(posedge clk);
         #1;
      end

      // Idle run
      do_reset();
      idle(10);
      read_now(32'h0000_0100);
      check("idle_done", 32'(done), 32'd0);
      check("idle_cnt", cycle_count, 32'd10);
      check("idle_rdata", mem_rdata, 32'd0);

      // Pass at cycle 5
      do_reset();
      idle(5);
      step(1, 0, BASE, 32'h1);
      check("pass_done", 32'(done), 32'd1);
      check("pass_pass", 32'(pass), 32'd1);
      check("pass_cnt", cycle_count, 32'd6);
      read_now(BASE + 32'hC);
      check("pass_status", mem_rdata, 32'd3);
      idle(3);
      check("pass_cnt_frozen", cycle_count, 32'd6);

      // Fail code and sticky verdict
      do_reset();
      step(1, 0, BASE, 32'hB);
      check("fail_done", 32'(done), 32'd1);
      check("fail_pass", 32'(pass), 32'd0);
      check("fail_code", fail_code, 32'd5);
      step(1, 0, BASE, 32'h1);
      check("fail_sticky_pass", 32'(pass), 32'd0);
      check("fail_sticky_code", fail_code, 32'd5);

      // Back-to-back console strobes, none after done
      do_reset();
      step(1, 0, BASE + 32'h4, 32'h48);
      check("putc1_valid", 32'(char_valid), 32'd1);
      check("putc1_data", 32'(char_data), 32'h48);
      step(1, 0, BASE + 32'h4, 32'h69);
      check("putc2_valid", 32'(char_valid), 32'd1);
      check("putc2_data", 32'(char_data), 32'h69);
      step(1, 0, BASE, 32'h1);
      check("putc3_valid", 32'(char_valid), 32'd0);
      step(1, 0, BASE + 32'h4, 32'h21);
      check("putc_after_done", 32'(char_valid), 32'd0);

      // Watchdog timeout
      do_reset();
      idle(TO - 1);
      check("tmo_pre_done", 32'(done), 32'd0);
      idle(1);
      check("tmo_done", 32'(done), 32'd1);
      check("tmo_pass", 32'(pass), 32'd0);
      check("tmo_code", fail_code, 32'h0000_DEAD);
      check("tmo_cnt", cycle_count, 32'(TO));
      read_now(BASE + 32'hC);
      check("tmo_status", mem_rdata, 32'd5);

      // TOHOST=1 on the expiry edge wins
      do_reset();
      idle(TO - 1);
      step(1, 0, BASE, 32'h1);
      check("race_pass", 32'(pass), 32'd1);
      check("race_code", fail_code, 32'd0);
      read_now(BASE + 32'hC);
      check("race_status", mem_rdata, 32'd3);

      // Asynchronous reset mid-strobe
      do_reset();
      idle(6);
      step(1, 0, BASE + 32'h4, 32'h41);
      check("arst_pre_valid", 32'(char_valid), 32'd1);
      mem_we = 0; mem_re = 0; mem_addr = '0; mem_wdata = '0;
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(char_valid), 32'd0);
      check("arst_data", 32'(char_data), 32'd0);
      check("arst_cnt", cycle_count, 32'd0);
      check("arst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      idle(3);
      check("arst_restart_cnt", cycle_count, 32'd3);

      // Randomized traffic against the model
      for (int run = 0; run < 30; run++) begin
         do_reset();
         for (int c = 0; c < 40; c++) begin
            logic [31:0] a, d;
            logic we, re;
            case ($urandom_range(0, 5))
               0, 1, 2, 3: a = BASE + 32'($urandom_range(0, 15));
               4:          a = $urandom();
               default:    a = BASE ^ (32'h10 << $urandom_range(0, 27));
            endcase
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            d  = $urandom();
            if (a[3:2] == 2'd0 && $urandom_range(0, 7) != 0) d = '0;
            else if (a[3:2] == 2'd0 && $urandom_range(0, 3) == 0) d = 32'h1;
            step(we, re, a, d);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sim_ctrl.md
# sim_ctrl

Memory-mapped simulation-control responder on the CPU data-memory bus. It decodes CPU stores and loads to a 16-byte window and terminates a program run with a pass/fail verdict. It streams console characters, counts cycles and enforces a watchdog timeout. It is the CPU-facing counterpart of the clock/reset stimulus: the bench drives `clk`/`rst` into `cpu`, and the program reports back to the bench through this block.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000: word-aligned base of the 16-byte register window.
- `TIMEOUT`, 1000: watchdog limit in cycles (≥ 2).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_we`  in  1  CPU store strobe for the current cycle.
- `mem_re`  in  1  CPU load strobe for the current cycle.
- `mem_addr`  in  32  CPU byte address.
- `mem_wdata`  in  32  CPU store data.
- `mem_rdata`  out  32  load data; combinational.
- `hit`  out  1  `mem_addr` is inside the window; combinational; used by the bus mux.
- `done`  out  1  run finished; sticky.
- `pass`  out  1  run finished with pass verdict; sticky.
- `fail_code`  out  32  failure code; valid while `done && !pass`.
- `cycle_count`  out  32  cycles spent in RUN.
- `char_valid`  out  1  one-cycle console-character strobe.
- `char_data`  out  8  console character.

## Operation
- Register offsets from `BASE_ADDR`:
  - 0x0 TOHOST, write-only.
  - 0x4 PUTC, write-only.
  - 0x8 CYCLE, read-only.
  - 0xC STATUS, read-only: {29'b0, timeout, pass, done}.
- Decode:
  - `hit` = (`mem_addr[31:4]` == `BASE_ADDR[31:4]`).
  - `mem_addr[1:0]` is ignored.
  - Writes to read-only offsets and reads of write-only offsets have no effect and return 0.
  - `mem_rdata` = 0 when `!hit` or `!mem_re`.
- States: RUN, PASS, FAIL, TMO. Reset state is RUN.
- Transitions out of RUN:
  - TOHOST write, value 1 → PASS.
  - TOHOST write, other nonzero value v → FAIL, `fail_code` = v >> 1.
  - TOHOST write of 0 is ignored.
  - Watchdog expiry → TMO, `fail_code` = 32'h0000_DEAD.
- PASS, FAIL and TMO are terminal until `rst`.
- `done` = (state != RUN). `pass` = (state == PASS).
- `cycle_count`:
  - Increments every cycle while in RUN.
  - Freezes in any terminal state.
  - Saturates at 32'hFFFF_FFFF; never wraps.
- Watchdog expires on the edge where `cycle_count` == TIMEOUT-1 in RUN.
- PUTC write while in RUN: registers `char_valid`=1 and `char_data`=`mem_wdata[7:0]` for exactly one cycle. Back-to-back writes produce back-to-back strobes.
- After `done`, all writes are ignored, including PUTC. Reads remain live.
- Reset values: `done`=0, `pass`=0, `fail_code`=0, `cycle_count`=0, `char_valid`=0, `char_data`=0.

## Timing
- Reads are zero-latency: `mem_rdata` is combinational from `mem_addr`/`mem_re` and current registers, matching the single-cycle CPU load path.
- Write effects appear on the edge that samples `mem_we`. `done`, `pass`, `fail_code` and `char_valid` are visible the following cycle.
- A CYCLE read returns the pre-increment value for that cycle.
- TOHOST write and watchdog expiry on the same edge: the write wins (PASS or FAIL, not TMO).
- `mem_we` and `mem_re` asserted together: both are serviced. The read returns the old value.
- `rst` asserted at any time, including mid-`char_valid`: all outputs clear immediately (asynchronous) and the state returns to RUN.

## Configuration
- `SIM_CTRL_DISPLAY_EN` defined:
  - Each `char_valid` cycle does `$write` of `char_data`.
  - On entry to PASS, FAIL or TMO, `$display` prints the verdict, `fail_code` and `cycle_count`.
  - `$finish` is called one cycle after `done` rises.
- `SIM_CTRL_DISPLAY_EN` undefined: block is purely synthesizable with no system tasks. Port behaviour is identical.

## Structure
- `sim_ctrl_pkg`:
  - Register offsets (`OFF_TOHOST`, `OFF_PUTC`, `OFF_CYCLE`, `OFF_STATUS`).
  - State encoding for RUN, PASS, FAIL, TMO.
  - `TMO_CODE` = 32'h0000_DEAD.
- One sub-module, `sim_ctrl_watchdog`: the saturating cycle counter plus the expiry compare.
  - Inputs: `clk`, `rst`, `run`.
  - Outputs: `count`, `expire`.
- Decode, FSM and console strobe live in `sim_ctrl`.

## Test plan
- Reset, then hold 10 idle cycles → `done`=0, `cycle_count`=10, `mem_rdata`=0 for `mem_addr`=0x0000_0100.
- Store 1 to 0xFFFF_0000 at cycle 5 → `done`=1, `pass`=1 next cycle; `cycle_count` frozen at 6; STATUS read returns 3.
- Store 0x0000_000B to TOHOST → `done`=1, `pass`=0, `fail_code`=5; a later store of 1 is ignored.
- Stores of 0x48 then 0x69 to 0xFFFF_0004 on consecutive cycles → `char_valid` high 2 cycles with `char_data` 0x48 then 0x69; no strobe after `done`.
- With TIMEOUT=20 and no stores → TMO, `fail_code`=0xDEAD, STATUS=5. With TOHOST=1 on the expiry edge → PASS instead.
- Assert `rst` mid-run at cycle 7, asynchronously between edges → outputs clear before the next edge and counting restarts from 0.
